// File: rtl/point_scalar_mul_if.sv
// Request/result channel between the X448/EdDSA top level (master) and point_scalar_mul (slave).
interface point_scalar_mul_if #(
  parameter int N     = 448,
  parameter int NBITS = 448
);
  logic [NBITS-1:0] k;
  logic [N-1:0]     px, py, pt, pz;
  logic [N-1:0]     qx, qy, qt, qz;
  logic             req_valid;
  logic             req_ready;
  logic             req_busy;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output k, px, py, pt, pz, req_valid, res_ready,
    input  qx, qy, qt, qz, req_ready, req_busy, res_valid
  );

  modport slave (
    input  k, px, py, pt, pz, req_valid, res_ready,
    output qx, qy, qt, qz, req_ready, req_busy, res_valid
  );
endinterface

// File: rtl/point_scalar_mul.sv
// Q = k*P on curve448 by an MSB-first double-and-always-add ladder over one external point_add,
// finished by an affine add with the neutral element so that Q leaves with Z=1.
module point_scalar_mul #(
  parameter int N     = 448,
  parameter int NBITS = 448
) (
  input  logic              clk,
  input  logic              rst,
  point_scalar_mul_if.slave req_if,
  output logic [N-1:0]      pa_x1,
  output logic [N-1:0]      pa_y1,
  output logic [N-1:0]      pa_t1,
  output logic [N-1:0]      pa_z1,
  output logic [N-1:0]      pa_x2,
  output logic [N-1:0]      pa_y2,
  output logic [N-1:0]      pa_t2,
  output logic [N-1:0]      pa_z2,
  input  logic [N-1:0]      pa_x3,
  input  logic [N-1:0]      pa_y3,
  input  logic [N-1:0]      pa_t3,
  input  logic [N-1:0]      pa_z3,
  output logic              pa_affine,
  output logic              pa_req_valid,
  input  logic              pa_req_ready,
  input  logic              pa_req_busy,
  input  logic              pa_res_valid,
  output logic              pa_res_ready
);
  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [N-1:0] ONE = N'(1);

  typedef struct packed {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] t;
    logic [N-1:0] z;
  } pt_t;

  typedef enum logic [2:0] {IDLE, DBL, ADD, NRM, DONE} state_t;
  typedef enum logic [1:0] {OP_REQ, OP_WAIT, OP_ACK} phase_t;

  localparam pt_t NEUTRAL = {{N{1'b0}}, ONE, {N{1'b0}}, ONE};

  state_t           state;
  phase_t           phase;
  pt_t              r, s, b, q, op1, op2;
  pt_t              res, acc;
  logic [NBITS-1:0] kreg;
  logic [IW-1:0]    idx;

  assign {pa_x1, pa_y1, pa_t1, pa_z1} = op1;
  assign {pa_x2, pa_y2, pa_t2, pa_z2} = op2;
  assign res = {pa_x3, pa_y3, pa_t3, pa_z3};
  assign {req_if.qx, req_if.qy, req_if.qt, req_if.qz} = q;

  // The add result is always computed; the scalar bit only selects which register survives.
  assign acc = kreg[idx] ? s : r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      phase            <= OP_REQ;
      r                <= '0;
      s                <= '0;
      b                <= '0;
      q                <= '0;
      op1              <= '0;
      op2              <= '0;
      kreg             <= '0;
      idx              <= '0;
      pa_affine        <= 1'b0;
      pa_req_valid     <= 1'b0;
      pa_res_ready     <= 1'b0;
      req_if.req_ready <= 1'b0;
      req_if.req_busy  <= 1'b0;
      req_if.res_valid <= 1'b0;
    end else begin
      req_if.req_ready <= 1'b0;
      pa_res_ready     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_if.req_valid) begin
            req_if.req_ready <= 1'b1;
            req_if.req_busy  <= 1'b1;
            kreg             <= req_if.k;
            b                <= {req_if.px, req_if.py, req_if.pt, req_if.pz};
            r                <= NEUTRAL;
            idx              <= IW'(NBITS - 1);
            op1              <= NEUTRAL;
            op2              <= NEUTRAL;
            pa_affine        <= 1'b0;
            pa_req_valid     <= 1'b1;
            phase            <= OP_REQ;
            state            <= DBL;
          end
        end
        DONE: begin
          if (req_if.res_ready) begin
            req_if.res_valid <= 1'b0;
            state            <= IDLE;
          end
        end
        default: begin
          case (phase)
            OP_REQ: begin
              if (pa_req_ready) begin
                pa_req_valid <= 1'b0;
                phase        <= OP_WAIT;
              end
            end
            OP_WAIT: begin
              if (pa_res_valid && !pa_req_busy) begin
                pa_res_ready <= 1'b1;
                phase        <= OP_ACK;
                case (state)
                  DBL:     r <= res;
                  ADD:     s <= res;
                  default: q <= res;
                endcase
              end
            end
            default: begin
              // Operands for the next op are loaded only after the previous result was taken.
              phase <= OP_REQ;
              case (state)
                DBL: begin
                  op1          <= r;
                  op2          <= b;
                  pa_req_valid <= 1'b1;
                  state        <= ADD;
                end
                ADD: begin
                  r            <= acc;
                  op1          <= acc;
                  pa_req_valid <= 1'b1;
                  if (idx == '0) begin
                    op2       <= NEUTRAL;
                    pa_affine <= 1'b1;
                    state     <= NRM;
                  end else begin
                    op2   <= acc;
                    idx   <= idx - 1'b1;
                    state <= DBL;
                  end
                end
                default: begin
                  pa_affine        <= 1'b0;
                  req_if.res_valid <= 1'b1;
                  req_if.req_busy  <= 1'b0;
                  state            <= DONE;
                end
              endcase
            end
          endcase
        end
      endcase
    end
  end
endmodule

// File: tb/tb_point_scalar_mul.sv
// Bench for point_scalar_mul with a linear stand-in for point_add (coordinate-wise add around (0,1,0,1)),
// so k*P has a closed form: x=k*px, y=k*(py-1)+1, t=k*pt, z=1.
module tb_point_scalar_mul;
  localparam int N    = 96;
  localparam int NB   = 64;
  localparam int MAXC = 20000;

  typedef struct packed {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] t;
    logic [N-1:0] z;
  } pt4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  point_scalar_mul_if #(.N(N), .NBITS(NB)) rif ();

  logic [N-1:0] pa_x1, pa_y1, pa_t1, pa_z1, pa_x2, pa_y2, pa_t2, pa_z2;
  logic [N-1:0] pa_x3, pa_y3, pa_t3, pa_z3;
  logic pa_affine, pa_req_valid, pa_req_ready, pa_req_busy, pa_res_valid, pa_res_ready;

  point_scalar_mul #(.N(N), .NBITS(NB)) dut (
    .clk(clk), .rst(rst), .req_if(rif),
    .pa_x1(pa_x1), .pa_y1(pa_y1), .pa_t1(pa_t1), .pa_z1(pa_z1),
    .pa_x2(pa_x2), .pa_y2(pa_y2), .pa_t2(pa_t2), .pa_z2(pa_z2),
    .pa_x3(pa_x3), .pa_y3(pa_y3), .pa_t3(pa_t3), .pa_z3(pa_z3),
    .pa_affine(pa_affine), .pa_req_valid(pa_req_valid), .pa_req_ready(pa_req_ready),
    .pa_req_busy(pa_req_busy), .pa_res_valid(pa_res_valid), .pa_res_ready(pa_res_ready)
  );

  int total = 0;
  int bad   = 0;

  function automatic pt4 pa_model(pt4 a, pt4 b, logic aff);
    pt4 r;
    r.x = a.x + b.x;
    r.y = a.y + b.y - N'(1);
    r.t = a.t + b.t;
    r.z = aff ? N'(1) : a.z + b.z - N'(1);
    return r;
  endfunction

  function automatic pt4 mul_model(logic [NB-1:0] kv, pt4 p);
    pt4 r;
    logic [N-1:0] kk;
    kk  = N'(kv);
    r.x = kk * p.x;
    r.y = kk * (p.y - N'(1)) + N'(1);
    r.t = kk * p.t;
    r.z = N'(1);
    return r;
  endfunction

  // point_add stand-in: programmable ready/result delays, operand stability and protocol watch
  int rdy_dly = 0;
  int res_dly = 0;
  int op_cnt = 0, stab_err = 0, proto_err = 0;
  int s_st, s_cnt;
  pt4 snap1, snap2;
  logic snap_aff;
  pt4 op1_w, op2_w;
  assign op1_w = {pa_x1, pa_y1, pa_t1, pa_z1};
  assign op2_w = {pa_x2, pa_y2, pa_t2, pa_z2};

  always @(posedge clk) begin
    if (rst) begin
      s_st <= 0; s_cnt <= 0;
      pa_req_ready <= 1'b0; pa_req_busy <= 1'b0; pa_res_valid <= 1'b0;
      {pa_x3, pa_y3, pa_t3, pa_z3} <= '0;
    end else begin
      case (s_st)
        0: if (pa_req_valid) begin
             if (s_cnt >= rdy_dly) begin pa_req_ready <= 1'b1; s_st <= 1; s_cnt <= 0; end
             else s_cnt <= s_cnt + 1;
           end
        1: begin
             pa_req_ready <= 1'b0; pa_req_busy <= 1'b1;
             snap1 <= op1_w; snap2 <= op2_w; snap_aff <= pa_affine;
             op_cnt <= op_cnt + 1; s_st <= 2;
             if (!pa_req_valid) proto_err <= proto_err + 1;
           end
        2: begin
             if (op1_w !== snap1 || op2_w !== snap2 || pa_affine !== snap_aff) stab_err <= stab_err + 1;
             if (pa_req_valid) proto_err <= proto_err + 1;
             if (s_cnt >= res_dly) begin
               pa_res_valid <= 1'b1; pa_req_busy <= 1'b0;
               {pa_x3, pa_y3, pa_t3, pa_z3} <= pa_model(op1_w, op2_w, pa_affine);
               s_st <= 3; s_cnt <= 0;
             end else s_cnt <= s_cnt + 1;
           end
        default: begin
             if (op1_w !== snap1 || op2_w !== snap2 || pa_affine !== snap_aff) stab_err <= stab_err + 1;
             if (pa_req_valid) proto_err <= proto_err + 1;
             if (pa_res_ready) begin pa_res_valid <= 1'b0; s_st <= 0; end
           end
      endcase
    end
  end

  task automatic start_req(input logic [NB-1:0] kv, input pt4 p);
    int n;
    @(negedge clk);
    rif.k = kv; {rif.px, rif.py, rif.pt, rif.pz} = p; rif.req_valid = 1'b1;
    n = 0;
    while (!rif.req_ready && n < 10) begin @(negedge clk); n++; end
    total++;
    if (!rif.req_ready) begin bad++; $display("FAIL accept_timeout req_ready=%b required=1", rif.req_ready); end
    rif.req_valid = 1'b0;
  endtask

  task automatic run_req(input logic [NB-1:0] kv, input pt4 p, input bit do_ack,
                         output pt4 q, output int cyc);
    start_req(kv, p);
    cyc = 0;
    while (!rif.res_valid && cyc < MAXC) begin @(negedge clk); cyc++; end
    total++;
    if (!rif.res_valid) begin bad++; $display("FAIL result_timeout res_valid=%b required=1", rif.res_valid); end
    q = {rif.qx, rif.qy, rif.qt, rif.qz};
    if (do_ack) begin
      rif.res_ready = 1'b1; @(negedge clk); rif.res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [5:0] ctl;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ctl = {rif.req_ready, rif.req_busy, rif.res_valid, pa_req_valid, pa_res_ready, pa_affine};
    total++;
    if (ctl !== 6'b0) begin bad++; $display("FAIL reset_ctl got=%b required=000000", ctl); end
    total++;
    if ({rif.qx, rif.qy, rif.qt, rif.qz} !== '0) begin bad++; $display("FAIL reset_q got=%h required=0", {rif.qx, rif.qy, rif.qt, rif.qz}); end
    total++;
    if ({op1_w, op2_w} !== '0) begin bad++; $display("FAIL reset_operands got=%h required=0", {op1_w, op2_w}); end
    rst = 1'b0;
  endtask

  int cyc_k0, cyc_k1s;

  task automatic test_k0();
    pt4 q, exp_q; int base;
    base  = op_cnt;
    exp_q = {N'(0), N'(1), N'(0), N'(1)};
    run_req('0, {N'(5), N'(7), N'(11), N'(3)}, 1'b1, q, cyc_k0);
    total++;
    if (q !== exp_q) begin bad++; $display("FAIL k0_result got=%h required=%h", q, exp_q); end
    total++;
    if (op_cnt - base !== 2 * NB + 1) begin bad++; $display("FAIL k0_opcount got=%0d required=%0d", op_cnt - base, 2 * NB + 1); end
  endtask

  task automatic test_directed();
    logic [NB-1:0] kt [6];
    pt4 pv [6], ev [6];
    pt4 q; int cyc;
    kt[0] = 64'd1;   pv[0] = {N'(5), N'(7), N'(11), N'(3)}; ev[0] = {N'(5),   N'(7),   N'(11),  N'(1)};
    kt[1] = 64'd2;   pv[1] = {N'(5), N'(7), N'(11), N'(3)}; ev[1] = {N'(10),  N'(13),  N'(22),  N'(1)};
    kt[2] = 64'd3;   pv[2] = {N'(5), N'(7), N'(11), N'(3)}; ev[2] = {N'(15),  N'(19),  N'(33),  N'(1)};
    kt[3] = 64'd165; pv[3] = {N'(2), N'(3), N'(4),  N'(9)}; ev[3] = {N'(330), N'(331), N'(660), N'(1)};
    kt[4] = '1;      pv[4] = {N'(1), N'(2), N'(3),  N'(5)};
    ev[4] = {96'h0000_0000_FFFF_FFFF_FFFF_FFFF, 96'h0000_0001_0000_0000_0000_0000,
             96'h0000_0002_FFFF_FFFF_FFFF_FFFD, N'(1)};
    kt[5] = 64'h8000_0000_0000_0000; pv[5] = {N'(1), N'(1), N'(2), N'(7)};
    ev[5] = {96'h0000_0000_8000_0000_0000_0000, N'(1), 96'h0000_0001_0000_0000_0000_0000, N'(1)};
    for (int i = 0; i < 6; i++) begin
      run_req(kt[i], pv[i], 1'b1, q, cyc);
      if (i == 4) cyc_k1s = cyc;
      total++;
      if (q !== ev[i]) begin bad++; $display("FAIL directed_%0d got=%h required=%h", i, q, ev[i]); end
    end
  endtask

  task automatic test_random();
    pt4 p, q, e; logic [NB-1:0] kv; int cyc;
    for (int i = 0; i < 20; i++) begin
      kv = {$urandom, $urandom};
      p  = {{$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}};
      e  = mul_model(kv, p);
      run_req(kv, p, 1'b1, q, cyc);
      total++;
      if (q !== e) begin bad++; $display("FAIL random_%0d k=%h got=%h required=%h", i, kv, q, e); end
    end
  endtask

  task automatic test_timing();
    total++;
    if (cyc_k0 !== cyc_k1s) begin bad++; $display("FAIL const_time k0_cycles=%0d required=%0d (all-ones)", cyc_k0, cyc_k1s); end
  endtask

  task automatic test_hold();
    pt4 q, held; int cyc, unstable, accepted;
    run_req(64'd3, {N'(5), N'(7), N'(11), N'(3)}, 1'b0, q, cyc);
    unstable = 0; accepted = 0;
    for (int i = 0; i < 50; i++) begin
      rif.req_valid = (i >= 10 && i < 30);
      @(negedge clk);
      held = {rif.qx, rif.qy, rif.qt, rif.qz};
      if (!rif.res_valid || rif.req_busy || held !== q) unstable++;
      if (rif.req_ready) accepted++;
    end
    rif.req_valid = 1'b0;
    total++;
    if (unstable !== 0) begin bad++; $display("FAIL done_hold unstable_cycles=%0d required=0", unstable); end
    total++;
    if (accepted !== 0) begin bad++; $display("FAIL done_ignores_req accepts=%0d required=0", accepted); end
    total++;
    if (q !== {N'(15), N'(19), N'(33), N'(1)}) begin bad++; $display("FAIL hold_result got=%h required=15/19/33/1", q); end
    rif.res_ready = 1'b1; @(negedge clk); rif.res_ready = 1'b0;
    total++;
    if (rif.res_valid !== 1'b0) begin bad++; $display("FAIL done_release res_valid=%b required=0", rif.res_valid); end
  endtask

  task automatic test_reset_mid();
    int base, n; logic [5:0] ctl; pt4 q; int cyc;
    base = op_cnt;
    start_req(64'hFFFF_0000_1234_5678, {N'(9), N'(4), N'(6), N'(2)});
    n = 0;
    // ADD of bit 40 is op number 2*(NB-1-40)+2
    while (op_cnt - base < 2 * (NB - 1 - 40) + 2 && n < MAXC) begin @(negedge clk); n++; end
    total++;
    if (op_cnt - base < 2 * (NB - 1 - 40) + 2) begin bad++; $display("FAIL midop_timeout ops=%0d required=%0d", op_cnt - base, 2 * (NB - 1 - 40) + 2); end
    rst = 1'b1;
    @(negedge clk);
    ctl = {rif.req_ready, rif.req_busy, rif.res_valid, pa_req_valid, pa_res_ready, pa_affine};
    total++;
    if (ctl !== 6'b0 || {rif.qx, rif.qy, rif.qt, rif.qz} !== '0 || {op1_w, op2_w} !== '0) begin
      bad++; $display("FAIL midop_reset ctl=%b q=%h required all zero", ctl, {rif.qx, rif.qy, rif.qt, rif.qz});
    end
    rst = 1'b0;
    run_req(64'd2, {N'(5), N'(7), N'(11), N'(3)}, 1'b1, q, cyc);
    total++;
    if (q !== {N'(10), N'(13), N'(22), N'(1)}) begin bad++; $display("FAIL after_reset got=%h required=10/13/22/1", q); end
  endtask

  task automatic test_slow();
    pt4 p, q, e; int cyc, se;
    rdy_dly = 7; res_dly = 30;
    se = stab_err;
    p  = {N'(96'h1234_5678_9ABC), N'(17), N'(96'hDEAD_BEEF), N'(4)};
    e  = mul_model(64'h1234_5678_9ABC_DEF0, p);
    run_req(64'h1234_5678_9ABC_DEF0, p, 1'b1, q, cyc);
    total++;
    if (q !== e) begin bad++; $display("FAIL slow_result got=%h required=%h", q, e); end
    total++;
    if (stab_err - se !== 0) begin bad++; $display("FAIL slow_stability changes=%0d required=0", stab_err - se); end
    rdy_dly = 0; res_dly = 0;
  endtask

  task automatic test_protocol();
    total++;
    if (stab_err !== 0) begin bad++; $display("FAIL operand_stability changes=%0d required=0", stab_err); end
    total++;
    if (proto_err !== 0) begin bad++; $display("FAIL pa_handshake violations=%0d required=0", proto_err); end
  endtask

  initial begin
    rif.k = '0; rif.px = '0; rif.py = '0; rif.pt = '0; rif.pz = '0;
    rif.req_valid = 1'b0; rif.res_ready = 1'b0;
    test_reset();
    test_k0();
    test_directed();
    test_random();
    test_timing();
    test_hold();
    test_reset_mid();
    test_slow();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
